spi_sensor_rx_multich: RTL

//  Single-clock, oversampling SPI slave receiver (read-only, no MISO) for framed sensor packets from the MCU.

---
 rtl/spi_sensor_rx_multich.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_sensor_rx_multich.sv
// Oversampling SPI slave receiver for framed multi-channel sensor packets.
// Frames are demuxed by a channel-ID byte into per-channel register banks.
// Each frame is checked for length, header, channel ID and XOR checksum.
// Frame statistics are kept in saturating counters.

package spi_sensor_pkg;
  typedef struct packed {
    logic [15:0] roll;
    logic [15:0] pitch;
    logic [15:0] yaw;
    logic [15:0] gx;
    logic [15:0] gy;
    logic [15:0] gz;
    logic        euler_valid;
    logic        gyro_valid;
  } sensor_rec_t;
endpackage

// One channel's register bank. It loads the whole staged record on a
// publish strobe that is aimed at this channel.
module spi_sensor_ch_regs
  import spi_sensor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  sensor_rec_t din,
  output sensor_rec_t q
);
  // hold the last good record for this channel
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= din;
  end
endmodule

module spi_sensor_rx_multich
  import spi_sensor_pkg::*;
#(
  parameter int          NUM_CH    = 2,
  parameter int          PKT_BYTES = 16,
  parameter logic [7:0]  HEADER    = 8'hAA,
  parameter bit          CPOL      = 1'b0,
  parameter bit          CPHA      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs_n,
  input  logic                  sck,
  input  logic                  sdi,
  output logic [16*NUM_CH-1:0]  ch_roll,
  output logic [16*NUM_CH-1:0]  ch_pitch,
  output logic [16*NUM_CH-1:0]  ch_yaw,
  output logic [16*NUM_CH-1:0]  ch_gx,
  output logic [16*NUM_CH-1:0]  ch_gy,
  output logic [16*NUM_CH-1:0]  ch_gz,
  output logic [NUM_CH-1:0]     ch_euler_valid,
  output logic [NUM_CH-1:0]     ch_gyro_valid,
  output logic [NUM_CH-1:0]     ch_update,
  output logic                  frame_ok,
  output logic [3:0]            err_flags,
  input  logic                  err_clr,
  output logic [15:0]           good_cnt,
  output logic [15:0]           bad_cnt
);
  // byte_cnt must reach PKT_BYTES+1, which marks an overrun
  localparam int  BCW         = $clog2(PKT_BYTES + 2);
  localparam bit  SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic [1:0] {IDLE, RX, CHECK, PUBLISH} state_t;
  state_t state, nxt;

  logic [1:0] cs_s, sck_s, sdi_s;
  logic       cs_d, sck_d, cs_pend;
  logic       cs_sync, sck_sync, sdi_sync, cs_fall, sck_edge;

  logic [2:0]        bit_cnt;
  logic [BCW-1:0]    byte_cnt;
  logic [6:0]        shreg;
  logic [7:0]        byte_in, xsum, ck_rx;
  logic [13:0][7:0]  stg;
  logic [1:0]        flags;

  logic              start, pub;
  logic [3:0]        err_set;
  logic              len_err, hdr_err, ch_err, ck_err;
  logic [NUM_CH-1:0] ch_sel;
  sensor_rec_t       stg_rec;
  sensor_rec_t       ch_q [NUM_CH];

  assign cs_sync  = cs_s[1];
  assign sck_sync = sck_s[1];
  assign sdi_sync = sdi_s[1];
  assign cs_fall  = cs_d & ~cs_sync;
  assign sck_edge = SAMPLE_RISE ? (sck_sync & ~sck_d) : (~sck_sync & sck_d);
  assign byte_in  = {shreg, sdi_sync};

  // two-flop synchronisers plus delayed copies for edge detection; preset to idle bus
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_s  <= 2'b11;
      sck_s <= {2{CPOL}};
      sdi_s <= 2'b00;
      cs_d  <= 1'b1;
      sck_d <= CPOL;
    end else begin
      cs_s  <= {cs_s[0], cs_n};
      sck_s <= {sck_s[0], sck};
      sdi_s <= {sdi_s[0], sdi};
      cs_d  <= cs_sync;
      sck_d <= sck_sync;
    end
  end

  // remember a CS fall that lands while CHECK/PUBLISH are still finishing
  always_ff @(posedge clk) begin
    if (!rst_n) cs_pend <= 1'b0;
    else        cs_pend <= ~cs_sync & (cs_pend | cs_fall) & ~start;
  end

  assign len_err = (bit_cnt != 3'd0) || (byte_cnt != BCW'(PKT_BYTES));
  assign hdr_err = (stg[0] != HEADER);
  assign ch_err  = (stg[1] >= 8'(NUM_CH));
  assign ck_err  = (xsum != ck_rx);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state and control strobes; channel regs load as CHECK passes so
  // they become visible together with the PUBLISH-cycle pulses
  always_comb begin
    nxt     = state;
    start   = 1'b0;
    pub     = 1'b0;
    err_set = 4'b0000;
    case (state)
      IDLE: if (!cs_sync && (cs_fall || cs_pend)) begin
        nxt   = RX;
        start = 1'b1;
      end
      RX: if (cs_sync) nxt = CHECK;
      CHECK: begin
        if      (len_err) err_set = 4'b1000;
        else if (hdr_err) err_set = 4'b0001;
        else if (ch_err)  err_set = 4'b0010;
        else if (ck_err)  err_set = 4'b0100;
        if (err_set != 4'b0000) nxt = IDLE;
        else begin
          nxt = PUBLISH;
          pub = 1'b1;
        end
      end
      PUBLISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // bit/byte assembly, staging and running checksum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      xsum     <= '0;
      ck_rx    <= '0;
      stg      <= '0;
      flags    <= '0;
    end else if (start) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      xsum     <= '0;
    end else if (state == RX && !cs_sync && sck_edge) begin
      shreg   <= byte_in[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        if (byte_cnt < BCW'(14))  stg[byte_cnt[3:0]] <= byte_in;
        if (byte_cnt == BCW'(14)) flags <= byte_in[1:0];
        if (byte_cnt == BCW'(PKT_BYTES - 1)) ck_rx <= byte_in;
        else                                 xsum  <= xsum ^ byte_in;
        if (byte_cnt != BCW'(PKT_BYTES + 1)) byte_cnt <= byte_cnt + BCW'(1);
      end
    end
  end

  assign stg_rec = '{roll:  {stg[2],  stg[3]},  pitch: {stg[4],  stg[5]},
                     yaw:   {stg[6],  stg[7]},  gx:    {stg[8],  stg[9]},
                     gy:    {stg[10], stg[11]}, gz:    {stg[12], stg[13]},
                     euler_valid: flags[0], gyro_valid: flags[1]};

  // status pulses, sticky errors (a new error beats err_clr) and saturating counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_update <= '0;
      frame_ok  <= 1'b0;
      err_flags <= 4'b0000;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      ch_update <= pub ? ch_sel : '0;
      frame_ok  <= pub;
      err_flags <= (err_clr ? 4'b0000 : err_flags) | err_set;
      if (pub && good_cnt != 16'hFFFF)                  good_cnt <= good_cnt + 16'd1;
      if ((err_set != 4'b0000) && bad_cnt != 16'hFFFF)  bad_cnt  <= bad_cnt + 16'd1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_sel[c] = (stg[1] == 8'(c));

    spi_sensor_ch_regs u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (pub & ch_sel[c]),
      .din   (stg_rec),
      .q     (ch_q[c])
    );

    assign ch_roll [16*c +: 16] = ch_q[c].roll;
    assign ch_pitch[16*c +: 16] = ch_q[c].pitch;
    assign ch_yaw  [16*c +: 16] = ch_q[c].yaw;
    assign ch_gx   [16*c +: 16] = ch_q[c].gx;
    assign ch_gy   [16*c +: 16] = ch_q[c].gy;
    assign ch_gz   [16*c +: 16] = ch_q[c].gz;
    assign ch_euler_valid[c]    = ch_q[c].euler_valid;
    assign ch_gyro_valid[c]     = ch_q[c].gyro_valid;
  end
endmodule
